uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo_pkg.sv | 32 +++
 rtl/uart_fifo_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_fifo.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART with receive FIFO.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Bit positions inside the status byte
  localparam int STAT_RDRF = 0;
  localparam int STAT_TDRE = 1;
  localparam int STAT_FE   = 2;
  localparam int STAT_OVR  = 3;

  // eclk cycles per 16x tick, rounded to nearest and never below one
  function automatic int calc_div(input int clkspeed, input int baud);
    int d;
    d = (clkspeed + 8 * baud) / (16 * baud);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// CPU-side register bus of the UART: one-cycle strobe, read data and RX-ready flag.
interface uart_fifo_if;
  logic       cs_b;
  logic       rnw;
  logic       a0;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_ready;

  modport master (output cs_b, rnw, a0, din, input dout, rx_ready);
  modport slave  (input cs_b, rnw, a0, din, output dout, rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous FIFO for received characters; push and pop may share a cycle.
module uart_rx_fifo #(
  parameter int RXDEPTH = 16
) (
  input  logic                       eclk,
  input  logic                       erst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(RXDEPTH):0]   count
);

  localparam int AW = $clog2(RXDEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [RXDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(RXDEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Storage array, written only when a push is accepted
  always_ff @(posedge eclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright
  always_ff @(posedge eclk) begin
    if (erst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with 16x oversampling receiver, RX FIFO and a two-register CPU interface.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int CLKSPEED = 62500000,
  parameter int BAUD     = 115200,
  parameter int RXDEPTH  = 16
) (
  input  logic       eclk,
  input  logic       erst,
  uart_fifo_if.slave bus,
  input  logic       rxd,
  output logic       txd
);

  localparam int DIV = calc_div(CLKSPEED, BAUD);
  localparam int CW  = $clog2(RXDEPTH) + 1;

  logic [31:0] tick_cnt;
  logic        tick;

  // Bus decode; strobes are ignored while reset is asserted
  logic strobe, status_rd, data_rd, data_wr, ctrl_wr;
  assign strobe    = ~erst & ~bus.cs_b;
  assign status_rd = strobe & bus.rnw & ~bus.a0;
  assign data_rd   = strobe & bus.rnw & bus.a0;
  assign data_wr   = strobe & ~bus.rnw & bus.a0;
  assign ctrl_wr   = strobe & ~bus.rnw & ~bus.a0;

  // Free-running 16x baud tick divider
  always_ff @(posedge eclk) begin
    if (erst || tick) tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 32'd1;
  end
  assign tick = (tick_cnt == 32'(DIV - 1));

  // ---------------- Transmitter ----------------
  tx_state_t  tx_state, tx_next;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_shreg;
  logic       tx_load, tx_bit_end, tdre;

  assign tx_load    = data_wr & (tx_state == TX_IDLE);
  assign tx_bit_end = tick & (tx_tcnt == 4'd15);

  // TX state register
  always_ff @(posedge eclk) begin
    if (erst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  // TX next state: each non-idle state lasts one 16-tick bit time
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX line value and empty flag from the current state
  always_comb begin
    txd  = 1'b1;
    tdre = (tx_state == TX_IDLE);
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shreg[0];
      default:  txd = 1'b1;
    endcase
  end

  // TX bit timing and LSB-first shift register
  always_ff @(posedge eclk) begin
    if (erst) begin
      tx_tcnt  <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
    end else if (tx_load) begin
      tx_tcnt  <= '0;
      tx_idx   <= '0;
      tx_shreg <= bus.din;
    end else if (tx_state != TX_IDLE && tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_bit_end && tx_state == TX_DATA) begin
        tx_shreg <= {1'b0, tx_shreg[7:1]};
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  // ---------------- Receiver ----------------
  rx_state_t  rx_state, rx_next;
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev, rx_fall, rx_sample;
  logic [3:0] rx_tcnt, rx_target;
  logic [2:0] rx_idx;
  logic [7:0] rx_shreg;
  logic       rx_push, fe_set;

  // Two-flop synchronizer plus an edge-detect flop, all idling high
  always_ff @(posedge eclk) begin
    if (erst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end
  assign rx_s      = rx_sync[1];
  assign rx_fall   = rx_prev & ~rx_s;
  assign rx_target = (rx_state == RX_START) ? 4'd7 : 4'd15;
  assign rx_sample = tick & (rx_tcnt == rx_target);

  // RX state register
  always_ff @(posedge eclk) begin
    if (erst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // RX next state: half a bit to mid-start, then a full bit per sample
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_sample) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_sample) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX outcome of the stop-bit sample: deliver the byte or flag a framing error
  always_comb begin
    rx_push = (rx_state == RX_STOP) & rx_sample & rx_s;
    fe_set  = (rx_state == RX_STOP) & rx_sample & ~rx_s;
  end

  // RX tick phase counter and data shift register
  always_ff @(posedge eclk) begin
    if (erst) begin
      rx_tcnt  <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_tcnt <= '0;
      rx_idx  <= '0;
    end else if (tick) begin
      rx_tcnt <= rx_sample ? 4'd0 : rx_tcnt + 4'd1;
      if (rx_sample && rx_state == RX_DATA) begin
        rx_shreg <= {rx_s, rx_shreg[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
    end
  end

  // ---------------- FIFO and CPU registers ----------------
  logic [7:0]    fifo_head, dout_q, status;
  logic          fifo_full, fifo_empty, fifo_pop, flush, ovr_set, fe, ovr;
  logic [CW-1:0] fifo_count;

  assign flush    = ctrl_wr & bus.din[0];
  assign fifo_pop = data_rd & ~fifo_empty;
  assign ovr_set  = rx_push & fifo_full & ~fifo_pop & ~flush;

  uart_rx_fifo #(.RXDEPTH(RXDEPTH)) u_rx_fifo (
    .eclk  (eclk),
    .erst  (erst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (rx_shreg),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rx_ready = (fifo_count != '0);
  assign bus.dout     = dout_q;

  // Status byte assembled from live flags
  always_comb begin
    status            = '0;
    status[STAT_OVR]  = ovr;
    status[STAT_FE]   = fe;
    status[STAT_TDRE] = tdre;
    status[STAT_RDRF] = bus.rx_ready;
  end

  // Sticky error flags cleared by a status read, read data register
  always_ff @(posedge eclk) begin
    if (erst) begin
      fe     <= 1'b0;
      ovr    <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      fe  <= fe_set  | (fe  & ~status_rd);
      ovr <= ovr_set | (ovr & ~status_rd);
      if (status_rd)    dout_q <= status;
      else if (data_rd) dout_q <= fifo_empty ? 8'h00 : fifo_head;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Randomized scoreboard bench for uart_fifo against a queue-based behavioural model.
module tb_uart_fifo;

  localparam int CLKSPEED = 1600000;
  localparam int BAUD     = 100000;
  localparam int RXDEPTH  = 16;
  localparam int FRAME    = 160;

  logic eclk = 1'b0;
  logic erst;
  logic rxd;
  logic txd;

  uart_fifo_if bus ();

  uart_fifo #(.CLKSPEED(CLKSPEED), .BAUD(BAUD), .RXDEPTH(RXDEPTH)) dut (
    .eclk (eclk),
    .erst (erst),
    .bus  (bus.slave),
    .rxd  (rxd),
    .txd  (txd)
  );

  // Free-running clock, 10 ns period
  always #5 eclk = ~eclk;

  int edges = 0;
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Behavioural model state
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         m_fe  = 1'b0;
  bit         m_ovr = 1'b0;
  int         tx_w   = 0;
  int         tx_end = 0;
  logic [7:0] tx_byte = 8'h00;

  // Count of rising edges so far; read at falling edges
  always @(posedge eclk) edges <= edges + 1;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %02h expected %02h at edge %0d", name, act, want, edges);
    end
  endtask

  // Transmitter busy during the cycle after rising edge k
  function automatic bit tx_busy_at(input int k);
    return (k >= tx_w) && (k < tx_end);
  endfunction

  // Serial line value the model predicts for the cycle after rising edge k
  function automatic logic exp_txd(input int k);
    int b;
    if (!tx_busy_at(k)) return 1'b1;
    b = (k - tx_w) / 16;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return tx_byte[b-1];
  endfunction

  // Read monitor: every accepted read strobe is answered one cycle later
  initial begin
    logic [7:0] want;
    forever begin
      @(posedge eclk);
      if (mon_en && erst === 1'b0 && bus.cs_b === 1'b0 && bus.rnw === 1'b1) begin
        @(negedge eclk);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected read", bus.dout, 8'hxx);
        end else begin
          want = exp_q.pop_front();
          checkOutput("dout", bus.dout, want);
        end
      end
    end
  end

  // Serial output monitor, compared every cycle against the frame model
  initial begin
    forever begin
      @(negedge eclk);
      if (mon_en) checkOutput("txd", 8'(txd), 8'(exp_txd(edges)));
    end
  end

  // One CPU strobe; the model predicts its effect at the sampling edge
  task automatic applyStimulus(input bit rd, input bit a0, input logic [7:0] data);
    int e;
    logic [7:0] want;
    @(negedge eclk);
    checkOutput("rx_ready", 8'(bus.rx_ready), 8'(rx_q.size() != 0));
    e = edges;
    bus.cs_b = 1'b0;
    bus.rnw  = rd;
    bus.a0   = a0;
    bus.din  = data;
    if (rd) begin
      if (!a0) begin
        want    = 8'h00;
        want[3] = m_ovr;
        want[2] = m_fe;
        want[1] = !tx_busy_at(e);
        want[0] = (rx_q.size() != 0);
        exp_q.push_back(want);
        m_fe  = 1'b0;
        m_ovr = 1'b0;
      end else if (rx_q.size() != 0) begin
        exp_q.push_back(rx_q.pop_front());
      end else begin
        exp_q.push_back(8'h00);
      end
    end else if (a0) begin
      if (!tx_busy_at(e)) begin
        tx_w    = e + 1;
        tx_end  = e + 1 + FRAME;
        tx_byte = data;
      end
    end else if (data[0]) begin
      rx_q.delete();
    end
    @(negedge eclk);
    bus.cs_b = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge eclk);
  endtask

  // Drive a serial frame; cut short after 'limit' cycles when limit < FRAME
  task automatic rxFrame(input logic [7:0] b, input bit stop, input int limit);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10 && n < limit; i++) begin
      for (int c = 0; c < 16 && n < limit; c++) begin
        @(negedge eclk);
        rxd = bits[i];
        n++;
      end
    end
    if (n >= FRAME) begin
      if (!stop) m_fe = 1'b1;
      else if (rx_q.size() >= RXDEPTH) m_ovr = 1'b1;
      else rx_q.push_back(b);
      @(negedge eclk);
      rxd = 1'b1;
      waitCycles(4);
    end
  endtask

  // Synchronous reset with bus strobes that must be ignored while it is held
  task automatic applyReset();
    int e;
    @(negedge eclk);
    e = edges;
    erst     = 1'b1;
    rxd      = 1'b1;
    bus.cs_b = 1'b1;
    if (tx_end > e + 1) tx_end = e + 1;
    rx_q.delete();
    m_fe  = 1'b0;
    m_ovr = 1'b0;
    @(negedge eclk);
    bus.cs_b = 1'b0;
    bus.rnw  = 1'b0;
    bus.a0   = 1'b1;
    bus.din  = 8'hFF;
    @(negedge eclk);
    bus.rnw = 1'b1;
    @(negedge eclk);
    bus.cs_b = 1'b1;
    erst     = 1'b0;
    checkOutput("reset dout", bus.dout, 8'h00);
    checkOutput("reset rx_ready", 8'(bus.rx_ready), 8'h00);
    checkOutput("reset txd", 8'(txd), 8'h01);
    mon_en = 1'b1;
  endtask

  // Watchdog keeps the run bounded
  initial begin
    #(80000 * 10);
    $display("[TB] FAIL watchdog: got timeout, expected completion within 80000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    erst     = 1'b1;
    rxd      = 1'b1;
    bus.cs_b = 1'b1;
    bus.rnw  = 1'b1;
    bus.a0   = 1'b0;
    bus.din  = 8'h00;

    applyReset();
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h00);

    $display("[TB] transmit 0x55");
    applyStimulus(0, 1, 8'h55);
    waitCycles(80);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(0, 1, 8'hAA);
    waitCycles(90);
    applyStimulus(1, 0, 8'h00);

    $display("[TB] receive 0xA5");
    rxFrame(8'hA5, 1'b1, FRAME);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 0, 8'h00);

    $display("[TB] overrun with 17 frames");
    for (int i = 0; i < 17; i++) rxFrame(8'(i), 1'b1, FRAME);
    applyStimulus(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 8'h00);
    applyStimulus(1, 0, 8'h00);

    $display("[TB] framing error");
    rxFrame(8'h3C, 1'b0, FRAME);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 0, 8'h00);

    $display("[TB] false start then 0x81");
    for (int i = 0; i < 4; i++) begin
      @(negedge eclk);
      rxd = 1'b0;
    end
    @(negedge eclk);
    rxd = 1'b1;
    waitCycles(20);
    applyStimulus(1, 0, 8'h00);
    rxFrame(8'h81, 1'b1, FRAME);
    applyStimulus(1, 1, 8'h00);

    $display("[TB] flush");
    rxFrame(8'h11, 1'b1, FRAME);
    rxFrame(8'h22, 1'b1, FRAME);
    applyStimulus(0, 0, 8'h01);
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    rxFrame(8'($urandom), ($urandom_range(0, 9) != 0), FRAME);
        2:       applyStimulus(1, 0, 8'h00);
        3:       applyStimulus(1, 1, 8'h00);
        4:       applyStimulus(0, 1, 8'($urandom));
        default: applyStimulus(0, 0, 8'($urandom));
      endcase
      waitCycles($urandom_range(0, 20));
    end

    $display("[TB] reset mid-frame");
    waitCycles(FRAME + 4);
    rxFrame(8'h44, 1'b1, FRAME);
    applyStimulus(0, 1, 8'hC3);
    waitCycles(19);
    rxFrame(8'h5A, 1'b1, 50);
    applyReset();
    applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h00);

    waitCycles(4);
    checkOutput("read drain", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
